jtag_1149_d10_crc_pkt_chk: RTL and testbench

JTAG_1149_D10_CRC_PKT_CHK -- requirements
Module: jtag_1149_d10_crc_pkt_chk

---
 rtl/jtag_1149_d10_crc_pkg.sv | 34 +++
 rtl/jtag_1149_d10_crc_trailer_buf.sv | 40 ++++
 rtl/jtag_1149_d10_crc_pkt_chk.sv | 174 +++++++++++++++++
 tb/tb_jtag_1149_d10_crc_pkt_chk.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_1149_d10_crc_pkg.sv
// Shared types and constants for the CRC packet checker:
// FSM encoding, byte-enable codes, trailer length, CRC32 polynomial.
package jtag_1149_d10_crc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_CMP   = 2'd3
    } state_t;

    localparam logic [3:0] BE_1B = 4'b1000;
    localparam logic [3:0] BE_2B = 4'b1100;
    localparam logic [3:0] BE_3B = 4'b1110;
    localparam logic [3:0] BE_4B = 4'b1111;

    localparam int TRL_LEN = 4;

    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;

    // Byte enables for a word holding n bytes from the MSB lane down.
    function automatic logic [3:0] be_for(input logic [2:0] n);
        logic [3:0] be;
        case (n)
            3'd1:    be = BE_1B;
            3'd2:    be = BE_2B;
            3'd3:    be = BE_3B;
            3'd4:    be = BE_4B;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/jtag_1149_d10_crc_trailer_buf.sv
// 4-byte delay line holding the most recent bytes of a packet.
// Ports: start (load din as entry 0), push (shift din in), fill,
// pop (oldest byte leaves this cycle), oldest, trailer (MSB = oldest).
module jtag_1149_d10_crc_trailer_buf
    import jtag_1149_d10_crc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        push,
    input  logic [7:0]  din,
    output logic [2:0]  fill,
    output logic        pop,
    output logic [7:0]  oldest,
    output logic [31:0] trailer
);

    logic [31:0] word;
    logic        full;

    assign full    = (fill == 3'(TRL_LEN));
    assign pop     = push && full;
    assign oldest  = word[31:24];
    assign trailer = word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
            fill <= '0;
        end else if (start) begin
            word <= {24'h0, din};
            fill <= 3'd1;
        end else if (push) begin
            word <= {word[23:0], din};
            if (!full)
                fill <= fill + 3'd1;
        end
    end

endmodule

// File: rtl/jtag_1149_d10_crc_pkt_chk.sv
// Packet CRC checker: packs payload bytes into words for an external CRC
// engine, holds back the 4-byte trailer and compares it with crc_in.
// Ports: byte_* (input stream, valid/ready), data_valid/crc_data_be/data/
// data_eop (engine feed and clear), crc_in (engine result), chk_done/
// chk_pass/chk_err (verdict). Macro JTAG_1149_D10_CRC_STATS_EN adds the
// saturating pass_cnt/fail_cnt statistics outputs.
module jtag_1149_d10_crc_pkt_chk
    import jtag_1149_d10_crc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    input  logic             byte_sop,
    input  logic             byte_eop,
    output logic             byte_ready,
    output logic             data_valid,
    output logic [3:0]       crc_data_be,
    output logic [31:0]      data,
    output logic             data_eop,
    input  logic [31:0]      crc_in,
    output logic             chk_done,
    output logic             chk_pass,
    output logic             chk_err
`ifdef JTAG_1149_D10_CRC_STATS_EN
    ,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
`endif
);

    state_t      state;
    logic        accept;
    logic        start;
    logic        push;
    logic        pop;
    logic [2:0]  fill;
    logic [7:0]  oldest;
    logic [31:0] trailer;
    logic [31:0] pk_word;
    logic [31:0] pk_nxt;
    logic [1:0]  pk_cnt;
    logic [2:0]  pk_n;

    // byte_ready is only high in IDLE/RUN, so accept implies one of those.
    assign accept = byte_valid && byte_ready;
    assign start  = accept && byte_sop;
    assign push   = accept && !byte_sop && (state == ST_RUN);

    jtag_1149_d10_crc_trailer_buf u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .push    (push),
        .din     (byte_data),
        .fill    (fill),
        .pop     (pop),
        .oldest  (oldest),
        .trailer (trailer)
    );

    // Packer contents after this cycle's pop, if any.
    always_comb begin
        pk_nxt = pk_word;
        pk_n   = {1'b0, pk_cnt};
        if (pop) begin
            unique case (pk_cnt)
                2'd0: pk_nxt[31:24] = oldest;
                2'd1: pk_nxt[23:16] = oldest;
                2'd2: pk_nxt[15:8]  = oldest;
                2'd3: pk_nxt[7:0]   = oldest;
            endcase
            pk_n = pk_n + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pk_word     <= '0;
            pk_cnt      <= '0;
            byte_ready  <= 1'b0;
            data_valid  <= 1'b0;
            crc_data_be <= '0;
            data        <= '0;
            data_eop    <= 1'b0;
            chk_done    <= 1'b0;
            chk_pass    <= 1'b0;
            chk_err     <= 1'b0;
        end else begin
            byte_ready  <= 1'b1;
            data_valid  <= 1'b0;
            crc_data_be <= '0;
            data        <= '0;
            data_eop    <= 1'b0;
            chk_done    <= 1'b0;
            chk_pass    <= 1'b0;
            chk_err     <= 1'b0;
            unique case (state)
                ST_IDLE, ST_RUN: begin
                    if (start) begin
                        // New packet; a sop in RUN aborts the old one and
                        // a sop+eop byte is a one-byte runt.
                        pk_word <= '0;
                        pk_cnt  <= '0;
                        if (byte_eop || state == ST_RUN) begin
                            chk_done <= 1'b1;
                            chk_err  <= 1'b1;
                            data_eop <= 1'b1;
                        end
                        state <= byte_eop ? ST_IDLE : ST_RUN;
                    end else if (push && byte_eop) begin
                        pk_word <= '0;
                        pk_cnt  <= '0;
                        if (fill < 3'd3) begin
                            chk_done <= 1'b1;
                            chk_err  <= 1'b1;
                            data_eop <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            // Residual payload goes out in the FLUSH cycle.
                            data_valid  <= (pk_n != 3'd0);
                            crc_data_be <= be_for(pk_n);
                            data        <= pk_nxt;
                            byte_ready  <= 1'b0;
                            state       <= ST_FLUSH;
                        end
                    end else if (push) begin
                        if (pk_n == 3'd4) begin
                            data_valid  <= 1'b1;
                            crc_data_be <= BE_4B;
                            data        <= pk_nxt;
                            pk_word     <= '0;
                            pk_cnt      <= '0;
                        end else begin
                            pk_word <= pk_nxt;
                            pk_cnt  <= pk_n[1:0];
                        end
                    end
                end
                ST_FLUSH: begin
                    byte_ready <= 1'b0;
                    state      <= ST_CMP;
                end
                ST_CMP: begin
                    chk_done <= 1'b1;
                    data_eop <= 1'b1;
                    chk_pass <= (crc_in == trailer);
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef JTAG_1149_D10_CRC_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (chk_done) begin
            if (chk_pass) begin
                if (pass_cnt != '1)
                    pass_cnt <= pass_cnt + CNT_W'(1);
            end else begin
                if (fail_cnt != '1)
                    fail_cnt <= fail_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_jtag_1149_d10_crc_pkt_chk.sv
// Self-checking bench for jtag_1149_d10_crc_pkt_chk with an attached
// CRC32 engine and a packet-level reference model.
module tb_jtag_1149_d10_crc_pkt_chk;

    localparam int          CNT_W = 16;
    localparam logic [31:0] POLY  = 32'h04C11DB7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_sop = 1'b0;
    logic        byte_eop = 1'b0;
    logic        byte_ready;
    logic        data_valid;
    logic [3:0]  crc_data_be;
    logic [31:0] data;
    logic        data_eop;
    logic [31:0] crc_in;
    logic        chk_done;
    logic        chk_pass;
    logic        chk_err;
`ifdef JTAG_1149_D10_CRC_STATS_EN
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int exp_pc = 0;
    int exp_fc = 0;
    int n_done = 0;
    int n_eop = 0;
    int n_coll = 0;
    logic [31:0] got_w[$];
    logic [3:0]  got_be[$];

    always #5 clk = ~clk;

    jtag_1149_d10_crc_pkt_chk #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_sop    (byte_sop),
        .byte_eop    (byte_eop),
        .byte_ready  (byte_ready),
        .data_valid  (data_valid),
        .crc_data_be (crc_data_be),
        .data        (data),
        .data_eop    (data_eop),
        .crc_in      (crc_in),
        .chk_done    (chk_done),
        .chk_pass    (chk_pass),
        .chk_err     (chk_err)
`ifdef JTAG_1149_D10_CRC_STATS_EN
        ,
        .pass_cnt    (pass_cnt),
        .fail_cnt    (fail_cnt)
`endif
    );

    function automatic logic [31:0] crc_b(input logic [31:0] c,
                                          input logic [7:0] b);
        logic fb;
        for (int i = 7; i >= 0; i--) begin
            fb = c[31] ^ b[i];
            c = {c[30:0], 1'b0};
            if (fb) c = c ^ POLY;
        end
        return c;
    endfunction

    function automatic logic [31:0] crc_bytes(input logic [7:0] q[$]);
        logic [31:0] c;
        c = 32'h0;
        foreach (q[i]) c = crc_b(c, q[i]);
        return c;
    endfunction

    // CRC engine: MSB lane first, cleared by data_eop.
    logic [31:0] eng;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) eng <= 32'h0;
        else if (data_eop) eng <= 32'h0;
        else if (data_valid) begin
            logic [31:0] c;
            c = eng;
            for (int l = 3; l >= 0; l--)
                if (crc_data_be[l]) c = crc_b(c, data[8*l +: 8]);
            eng <= c;
        end
    end
    assign crc_in = eng;

    always @(negedge clk) begin
        if (data_valid) begin
            got_w.push_back(data);
            got_be.push_back(crc_data_be);
        end
        if (chk_done) n_done++;
        if (data_eop) n_eop++;
        if (data_valid && data_eop) n_coll++;
    end

    task automatic send_byte(input logic [7:0] d, input logic s,
                             input logic e);
        int n;
        n = 0;
        @(negedge clk);
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_byte ready timeout got=0 exp=1");
        end
        byte_valid = 1'b1;
        byte_data = d;
        byte_sop = s;
        byte_eop = e;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        byte_sop = 1'b0;
        byte_eop = 1'b0;
    endtask

    task automatic wait_verdict(input int dly, input logic ep,
                                input logic ee, input string nm);
        int  i;
        bit  seen;
        seen = 0;
        for (i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (chk_done) begin
                seen = 1;
                break;
            end
        end
        n_chk++;
        if (!seen || i != dly) begin
            n_fail++;
            $display("FAIL %s verdict_delay got=%0d exp=%0d", nm, i, dly);
        end
        n_chk++;
        if ({chk_pass, chk_err, data_eop, data_valid} !== {ep, ee, 2'b10}) begin
            n_fail++;
            $display("FAIL %s verdict pass/err/eop/dv got=%b%b%b%b exp=%b%b10",
                     nm, chk_pass, chk_err, data_eop, data_valid, ep, ee);
        end
        @(negedge clk);
        n_chk++;
        if (chk_done !== 1'b0 || data_eop !== 1'b0) begin
            n_fail++;
            $display("FAIL %s pulse_width done=%b eop=%b exp=00",
                     nm, chk_done, data_eop);
        end
    endtask

    task automatic check_stats(input string nm);
`ifdef JTAG_1149_D10_CRC_STATS_EN
        n_chk++;
        if (pass_cnt !== CNT_W'(exp_pc) || fail_cnt !== CNT_W'(exp_fc)) begin
            n_fail++;
            $display("FAIL %s stats got=%0d/%0d exp=%0d/%0d",
                     nm, pass_cnt, fail_cnt, exp_pc, exp_fc);
        end
`else
        if (nm.len() < 0) $display("%s", nm);
`endif
    endtask

    task automatic run_packet(input logic [7:0] pk[$], input bit skip,
                              input int garb, input string nm);
        int          n, d0, e0, nw;
        logic [7:0]  pay[$];
        logic [31:0] trl, ew;
        logic [3:0]  eb;
        logic        ep;
        n = pk.size();
        d0 = n_done;
        e0 = n_eop;
        repeat (garb) send_byte(8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
        got_w.delete();
        got_be.delete();
        for (int i = (skip ? 1 : 0); i < n; i++)
            send_byte(pk[i], (i == 0), (i == n - 1));
        if (n < 4) begin
            wait_verdict(1, 1'b0, 1'b1, nm);
            exp_fc++;
        end else begin
            for (int i = 0; i < n - 4; i++) pay.push_back(pk[i]);
            trl = {pk[n-4], pk[n-3], pk[n-2], pk[n-1]};
            ep = (crc_bytes(pay) == trl);
            wait_verdict(3, ep, 1'b0, nm);
            if (ep) exp_pc++;
            else exp_fc++;
        end
        n_chk++;
        if (n_done != d0 + 1) begin
            n_fail++;
            $display("FAIL %s done_count got=%0d exp=%0d", nm, n_done - d0, 1);
        end
        n_chk++;
        if (n_eop != e0 + 1) begin
            n_fail++;
            $display("FAIL %s eop_count got=%0d exp=%0d", nm, n_eop - e0, 1);
        end
        nw = (pay.size() + 3) / 4;
        n_chk++;
        if (got_w.size() != nw) begin
            n_fail++;
            $display("FAIL %s word_count got=%0d exp=%0d", nm, got_w.size(), nw);
        end else begin
            for (int w = 0; w < nw; w++) begin
                ew = 32'h0;
                eb = 4'h0;
                for (int b = 0; b < 4; b++)
                    if (4 * w + b < pay.size()) begin
                        ew[31-8*b -: 8] = pay[4*w+b];
                        eb[3-b] = 1'b1;
                    end
                n_chk++;
                if (got_w[w] !== ew || got_be[w] !== eb) begin
                    n_fail++;
                    $display("FAIL %s word%0d got=%h/%b exp=%h/%b",
                             nm, w, got_w[w], got_be[w], ew, eb);
                end
            end
        end
        check_stats(nm);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({byte_ready, data_valid, crc_data_be, data, data_eop,
             chk_done, chk_pass, chk_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b%b%h%h%b%b%b%b exp=0",
                     byte_ready, data_valid, crc_data_be, data, data_eop,
                     chk_done, chk_pass, chk_err);
        end
        check_stats("reset");
        rst_n = 1'b1;
        n_chk++;
        if (byte_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_early got=%b exp=0", byte_ready);
        end
        @(negedge clk);
        n_chk++;
        if (byte_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_rise got=%b exp=1", byte_ready);
        end
    endtask

    task automatic test_directed();
        logic [7:0] p[$];
        p = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h04, 8'hC1, 8'h1D, 8'hB7};
        run_packet(p, 0, 0, "word_full");
        p = '{8'h01, 8'h04, 8'hC1, 8'h1D, 8'hB7};
        run_packet(p, 0, 0, "flush_1b");
        p = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_packet(p, 0, 0, "empty_payload");
        p = '{8'h01, 8'h02, 8'h03};
        run_packet(p, 0, 0, "runt3");
        p = '{8'h5A};
        run_packet(p, 0, 0, "runt_sop_eop");
        p = '{8'h01, 8'h04, 8'hC1, 8'h1D, 8'hB6};
        run_packet(p, 0, 0, "bad_crc");
    endtask

    task automatic test_abort(input int nb);
        logic [7:0]  old[$];
        logic [7:0]  nw[$];
        logic [31:0] c;
        repeat (nb) old.push_back(8'($urandom));
        repeat (6) nw.push_back(8'($urandom));
        c = crc_bytes(nw);
        nw.push_back(c[31:24]);
        nw.push_back(c[23:16]);
        nw.push_back(c[15:8]);
        nw.push_back(c[7:0]);
        got_w.delete();
        got_be.delete();
        for (int i = 0; i < nb; i++) send_byte(old[i], (i == 0), 1'b0);
        send_byte(nw[0], 1'b1, 1'b0);
        wait_verdict(1, 1'b0, 1'b1, "abort");
        exp_fc++;
        n_chk++;
        if (got_w.size() != (nb - 4) / 4) begin
            n_fail++;
            $display("FAIL abort word_count got=%0d exp=%0d",
                     got_w.size(), (nb - 4) / 4);
        end
        check_stats("abort");
        run_packet(nw, 1, 0, "after_abort");
    endtask

    task automatic test_random(input int n);
        logic [7:0]  pk[$];
        logic [31:0] c;
        int          r, len;
        for (int p = 0; p < n; p++) begin
            pk.delete();
            r = $urandom_range(0, 9);
            if (r == 0) begin
                len = $urandom_range(1, 3);
                repeat (len) pk.push_back(8'($urandom));
            end else begin
                len = $urandom_range(0, 13);
                repeat (len) pk.push_back(8'($urandom));
                c = crc_bytes(pk);
                if (r == 1) c = c ^ (32'h1 << $urandom_range(0, 31));
                pk.push_back(c[31:24]);
                pk.push_back(c[23:16]);
                pk.push_back(c[15:8]);
                pk.push_back(c[7:0]);
            end
            run_packet(pk, 0, ($urandom_range(0, 3) == 0) ? 2 : 0, "random");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] p[$];
        int d0;
        for (int i = 0; i < 7; i++) send_byte(8'($urandom), (i == 0), 1'b0);
        d0 = n_done;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({byte_ready, data_valid, chk_done, data_eop} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid outputs got=%b%b%b%b exp=0000",
                     byte_ready, data_valid, chk_done, data_eop);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_chk++;
        if (n_done != d0) begin
            n_fail++;
            $display("FAIL reset_mid dropped_verdict got=%0d exp=0", n_done - d0);
        end
        exp_pc = 0;
        exp_fc = 0;
        check_stats("reset_mid");
        p = '{8'h11, 8'h22, 8'h33, 8'h44};
        begin
            logic [31:0] c;
            c = crc_bytes(p);
            p.push_back(c[31:24]);
            p.push_back(c[23:16]);
            p.push_back(c[15:8]);
            p.push_back(c[7:0]);
        end
        run_packet(p, 0, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort(6);
        test_abort(9);
        test_random(40);
        test_reset_mid();
        n_chk++;
        if (n_coll != 0) begin
            n_fail++;
            $display("FAIL dv_eop_overlap got=%0d exp=0", n_coll);
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
